// File: rtl/lin_recur.sv
// rtl/lin_recur.sv - iterative engine for a(k+2) = C1*a(k+1) + C0*a(k)
// Seeds and coefficients are latched at start; the result and overflow flag hold until the next start.
module lin_recur #(
    parameter int WIDTH      = 32,
    parameter int N_WIDTH    = 16,
    parameter int COEF_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_stb,
    input  logic                  i_abort,
    input  logic [N_WIDTH-1:0]    i_n,
    input  logic [WIDTH-1:0]      i_seed0,
    input  logic [WIDTH-1:0]      i_seed1,
    input  logic [COEF_WIDTH-1:0] i_coef0,
    input  logic [COEF_WIDTH-1:0] i_coef1,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [WIDTH-1:0]      o_result,
    output logic                  o_ovf
);

    localparam int EXT = WIDTH + COEF_WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic [N_WIDTH-1:0]    r_cnt;
    logic [COEF_WIDTH-1:0] r_c0;
    logic [COEF_WIDTH-1:0] r_c1;
    logic                  r_done;
    logic [WIDTH-1:0]      r_result;
    logic                  r_ovf;

    logic [EXT-1:0] w_c0_ext;
    logic [EXT-1:0] w_c1_ext;
    logic [EXT-1:0] w_a_ext;
    logic [EXT-1:0] w_b_ext;
    logic [EXT-1:0] w_next;
    logic           w_wrap;

    assign w_c0_ext = {{(EXT-COEF_WIDTH){1'b0}}, r_c0};
    assign w_c1_ext = {{(EXT-COEF_WIDTH){1'b0}}, r_c1};
    assign w_a_ext  = {{(EXT-WIDTH){1'b0}}, r_a};
    assign w_b_ext  = {{(EXT-WIDTH){1'b0}}, r_b};
    assign w_next   = w_c1_ext * w_b_ext + w_c0_ext * w_a_ext;
    assign w_wrap   = |w_next[EXT-1:WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_c0     <= '0;
            r_c1     <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_stb) begin
                        r_c0    <= i_coef0;
                        r_c1    <= i_coef1;
                        r_a     <= i_seed0;
                        r_b     <= i_seed1;
                        r_cnt   <= i_n;
                        r_ovf   <= 1'b0;
                        r_state <= (i_n == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_ovf   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_a   <= r_b;
                        r_b   <= w_next[WIDTH-1:0];
                        r_cnt <= r_cnt - 1'b1;
                        // The last update produces a(n+1), which is never reported.
                        if (w_wrap && (r_cnt > N_WIDTH'(1)))
                            r_ovf <= 1'b1;
                        if (r_cnt == N_WIDTH'(1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done   <= 1'b1;
                    r_result <= r_a;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state == S_RUN);
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_lin_recur.sv
// tb/tb_lin_recur.sv - directed self-checking bench for lin_recur
// A 32-bit and an 8-bit instance share the control stimulus.
module tb_lin_recur;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stb = 1'b0;
    logic        i_abort = 1'b0;
    logic [15:0] i_n = '0;
    logic [31:0] seed0_32 = '0, seed1_32 = '0;
    logic [7:0]  seed0_8 = '0, seed1_8 = '0;
    logic [7:0]  i_coef0 = '0, i_coef1 = '0;

    logic        busy32, done32, ovf32;
    logic [31:0] res32;
    logic        busy8, done8, ovf8;
    logic [7:0]  res8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lin_recur #(.WIDTH(32), .N_WIDTH(16), .COEF_WIDTH(8)) dut32 (
        .i_clk(clk), .i_reset(i_reset), .i_stb(i_stb), .i_abort(i_abort), .i_n(i_n),
        .i_seed0(seed0_32), .i_seed1(seed1_32), .i_coef0(i_coef0), .i_coef1(i_coef1),
        .o_busy(busy32), .o_done(done32), .o_result(res32), .o_ovf(ovf32)
    );

    lin_recur #(.WIDTH(8), .N_WIDTH(16), .COEF_WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset(i_reset), .i_stb(i_stb), .i_abort(i_abort), .i_n(i_n),
        .i_seed0(seed0_8), .i_seed1(seed1_8), .i_coef0(i_coef0), .i_coef1(i_coef1),
        .o_busy(busy8), .o_done(done8), .o_result(res8), .o_ovf(ovf8)
    );

    task automatic start(input logic [15:0] n, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [7:0] c0, input logic [7:0] c1);
        @(negedge clk);
        i_n = n; seed0_32 = s0; seed1_32 = s1;
        seed0_8 = s0[7:0]; seed1_8 = s1[7:0];
        i_coef0 = c0; i_coef1 = c1;
        i_stb = 1'b1;
        @(negedge clk);
        i_stb = 1'b0;
    endtask

    // Entered at the negedge right after the accept edge (index 0); runs exactly `limit` cycles.
    task automatic wait_done(input bit w8, input int limit, input int stb_at,
                             output int busy_cnt, output int done_idx, output int done_cnt,
                             output logic [31:0] result, output logic ovf);
        busy_cnt = 0; done_idx = -1; done_cnt = 0; result = '0; ovf = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (w8 ? busy8 : busy32) busy_cnt++;
            if (w8 ? done8 : done32) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx = i;
                    result = w8 ? {24'd0, res8} : res32;
                    ovf = w8 ? ovf8 : ovf32;
                end
            end
            i_stb = (i == stb_at);
            if (i == stb_at) i_n = 16'd3;
            @(negedge clk);
        end
        i_stb = 1'b0;
    endtask

    task automatic run_check(input string name, input bit w8, input logic [15:0] n,
                             input logic [31:0] s0, input logic [31:0] s1,
                             input logic [7:0] c0, input logic [7:0] c1,
                             input int stb_at, input logic [31:0] exp_res, input logic exp_ovf);
        int busy_cnt, done_idx, done_cnt;
        logic [31:0] result;
        logic ovf;
        start(n, s0, s1, c0, c1);
        wait_done(w8, int'(n) + 4, stb_at, busy_cnt, done_idx, done_cnt, result, ovf);
        checks++;
        if (busy_cnt !== int'(n)) begin
            failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt, n);
        end
        checks++;
        if (done_idx !== int'(n) + 1 || done_cnt !== 1) begin
            failures++; $display("FAIL %s done_timing got idx=%0d cnt=%0d exp idx=%0d cnt=1", name, done_idx, done_cnt, int'(n) + 1);
        end
        checks++;
        if (result !== exp_res) begin
            failures++; $display("FAIL %s result got=%0d exp=%0d", name, result, exp_res);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            failures++; $display("FAIL %s ovf got=%0b exp=%0b", name, ovf, exp_ovf);
        end
        checks++;
        if ((w8 ? {24'd0, res8} : res32) !== exp_res) begin
            failures++; $display("FAIL %s result_hold got=%0d exp=%0d", name, w8 ? {24'd0, res8} : res32, exp_res);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy32, done32, ovf32, res32} !== 35'd0 || {busy8, done8, ovf8, res8} !== 11'd0) begin
            failures++; $display("FAIL reset_state got32=%0b%0b%0b/%0d got8=%0b%0b%0b/%0d exp=0", busy32, done32, ovf32, res32, busy8, done8, ovf8, res8);
        end
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fibonacci();
        run_check("fib10", 1'b0, 16'd10, 32'd0, 32'd1, 8'd1, 8'd1, -1, 32'd55, 1'b0);
    endtask

    task automatic test_small_n();
        run_check("n0", 1'b0, 16'd0, 32'd7, 32'd9, 8'd1, 8'd1, -1, 32'd7, 1'b0);
        run_check("n1", 1'b0, 16'd1, 32'd7, 32'd9, 8'd1, 8'd1, -1, 32'd9, 1'b0);
        run_check("zero_coef", 1'b0, 16'd4, 32'd7, 32'd9, 8'd0, 8'd0, -1, 32'd0, 1'b0);
    endtask

    task automatic test_other_sequences();
        run_check("pell5", 1'b0, 16'd5, 32'd0, 32'd1, 8'd1, 8'd2, -1, 32'd29, 1'b0);
        run_check("jacob6", 1'b0, 16'd6, 32'd0, 32'd1, 8'd2, 8'd1, -1, 32'd21, 1'b0);
    endtask

    task automatic test_overflow();
        run_check("w8_fib13", 1'b1, 16'd13, 32'd0, 32'd1, 8'd1, 8'd1, -1, 32'd233, 1'b0);
        run_check("w8_fib14", 1'b1, 16'd14, 32'd0, 32'd1, 8'd1, 8'd1, -1, 32'd121, 1'b1);
        run_check("w8_fib3", 1'b1, 16'd3, 32'd0, 32'd1, 8'd1, 8'd1, -1, 32'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_check("stb_ignored", 1'b0, 16'd20, 32'd0, 32'd1, 8'd1, 8'd1, 3, 32'd6765, 1'b0);
    endtask

    task automatic test_abort();
        int stray;
        start(16'd20, 32'd0, 32'd1, 8'd1, 8'd1);
        repeat (4) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if (busy32 !== 1'b0) begin
            failures++; $display("FAIL abort_idle busy got=%0b exp=0", busy32);
        end
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            if (done32) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin
            failures++; $display("FAIL abort_no_done pulses got=%0d exp=0", stray);
        end
        checks++;
        if (res32 !== 32'd6765 || ovf32 !== 1'b0) begin
            failures++; $display("FAIL abort_hold result got=%0d ovf=%0b exp=6765 ovf=0", res32, ovf32);
        end
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checks++;
        if (busy32 !== 1'b0 || res32 !== 32'd6765) begin
            failures++; $display("FAIL abort_idle_noeffect got busy=%0b result=%0d exp busy=0 result=6765", busy32, res32);
        end
    endtask

    task automatic test_reset_mid_run();
        int stray;
        start(16'd20, 32'd0, 32'd1, 8'd1, 8'd1);
        repeat (4) @(negedge clk);
        i_reset = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        i_abort = 1'b0;
        checks++;
        if ({busy32, done32, ovf32, res32} !== 35'd0) begin
            failures++; $display("FAIL reset_mid_run got busy=%0b done=%0b ovf=%0b result=%0d exp all 0", busy32, done32, ovf32, res32);
        end
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            if (done32 || busy32) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0 || res32 !== 32'd0) begin
            failures++; $display("FAIL reset_quiet activity got=%0d result=%0d exp 0/0", stray, res32);
        end
    endtask

    initial begin
        test_reset();
        test_fibonacci();
        test_small_n();
        test_other_sequences();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
